// File: rtl/result_collect.sv
// Collects NUM_CLASS fixed-point scores into one packed frame and
// issues a single write strobe toward the result memory.
module result_collect #(
   parameter int NUM_CLASS  = 10,
   parameter int SCORE_W    = 16,
   parameter int FRAC_SHIFT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          in_valid,
   input  logic [31:0]                   in_data,
   output logic                          in_ready,
   output logic [NUM_CLASS*SCORE_W-1:0]  write_result_data,
   output logic                          write_result_signal,
   output logic                          busy
);

   localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
   localparam int DW = NUM_CLASS * SCORE_W;
   localparam logic [CW-1:0] LAST = CW'(NUM_CLASS - 1);
   localparam logic signed [31:0] SMAX = (32'sd1 <<< (SCORE_W - 1)) - 32'sd1;
   localparam logic signed [31:0] SMIN = -(32'sd1 <<< (SCORE_W - 1));

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [DW-1:0]       pack;
   logic [DW-1:0]       pack_nxt;
   logic signed [31:0]  shifted;
   logic [SCORE_W-1:0]  score;
   logic                accept;
   logic                last;

   assign accept = in_valid & in_ready;
   assign last   = accept & (cnt == LAST);

   // Saturate the shifted accumulator into the signed score range
   always_comb begin
      shifted = $signed(in_data) >>> FRAC_SHIFT;
      if (shifted > SMAX)
         score = SMAX[SCORE_W-1:0];
      else if (shifted < SMIN)
         score = SMIN[SCORE_W-1:0];
      else
         score = shifted[SCORE_W-1:0];
   end

   always_comb begin
      pack_nxt = pack;
      pack_nxt[SCORE_W*cnt +: SCORE_W] = score;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COLLECT;
         COLLECT: begin
            if (abort)
               state_nxt = IDLE;
            else if (last)
               state_nxt = WRITE;
         end
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready            = (state == COLLECT);
      write_result_signal = (state == WRITE);
      busy                = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt               <= '0;
         pack              <= '0;
         write_result_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt  <= '0;
                  pack <= '0;
               end
            end
            COLLECT: begin
               if (abort) begin
                  cnt  <= '0;
                  pack <= '0;
               end else if (accept) begin
                  pack <= pack_nxt;
                  if (last) begin
                     write_result_data <= pack_nxt;
                     cnt               <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/result_collect.md
RESULT_COLLECT -- requirements
Module: result_collect

Interface
REQ-001 The block SHALL have parameter NUM_CLASS, default 10, the number of class scores per result frame.
REQ-002 The block SHALL have parameter SCORE_W, default 16, the width of one packed signed score.
REQ-003 The block SHALL have parameter FRAC_SHIFT, default 8, the arithmetic right-shift applied to each incoming accumulator value.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  one-cycle pulse that begins a new frame.
REQ-007 The block SHALL have port abort  input  1  discards the frame in progress.
REQ-008 The block SHALL have port in_valid  input  1  score beat valid.
REQ-009 The block SHALL have port in_data  input  32  signed fully-connected accumulator value for the current class.
REQ-010 The block SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-011 The block SHALL have port write_result_data  output  NUM_CLASS*SCORE_W (160)  packed frame for the result memory.
REQ-012 The block SHALL have port write_result_signal  output  1  one-cycle write strobe to the result memory.
REQ-013 The block SHALL have port busy  output  1  high while a frame is being collected or written.

Function
REQ-014 The block SHALL implement states IDLE, COLLECT, WRITE.
REQ-015 IDLE: in_ready=0, busy=0; start=1 -> COLLECT, slot counter cleared to 0, pack buffer cleared to 0.
REQ-016 COLLECT: in_ready=1, busy=1; a beat is accepted on the rising edge where in_valid=1 and in_ready=1.
REQ-017 An accepted beat SHALL be stored in bits [SCORE_W*k+SCORE_W-1 : SCORE_W*k] of the pack buffer, where k is the current slot counter; then k increments by 1.
REQ-018 Score conversion SHALL be: s = in_data >>> FRAC_SHIFT (arithmetic); s > 32767 -> 32767; s < -32768 -> -32768; otherwise the low SCORE_W bits of s.
REQ-019 Acceptance of the beat with k = NUM_CLASS-1 SHALL move COLLECT -> WRITE; the counter never exceeds NUM_CLASS-1 and never wraps within a frame.
REQ-020 WRITE: in_ready=0, busy=1, write_result_signal=1 for exactly one cycle; next state IDLE.
REQ-021 write_result_data SHALL be a register: loaded with the completed pack buffer on entry to WRITE, held unchanged at all other times until the next completed frame.
REQ-022 Latency: write_result_signal SHALL assert in the cycle immediately after the edge that accepted the last beat.
REQ-023 start while in COLLECT or WRITE SHALL be ignored.
REQ-024 start in the same cycle that WRITE returns to IDLE SHALL be ignored; a new start must arrive while in IDLE.
REQ-025 abort in COLLECT SHALL return to IDLE on the next edge, discard the buffer, leave write_result_data unchanged and produce no strobe.
REQ-026 abort coincident with acceptance of the final beat SHALL take priority: no transition to WRITE, no strobe.
REQ-027 abort in WRITE or IDLE SHALL have no effect; the in-flight strobe completes.
REQ-028 in_valid while in_ready=0 SHALL be ignored and SHALL not modify any state.

Reset
REQ-029 On rst=1 at a rising edge: state=IDLE, counter=0, pack buffer=0, write_result_data=0, write_result_signal=0, in_ready=0, busy=0.
REQ-030 rst SHALL override start, abort and in_valid in the same cycle; reset mid-frame produces no strobe.

Verification
REQ-031 Basic frame: start, then 10 consecutive beats in_data = k<<8 for k=0..9 -> one strobe, write_result_data = 0x0009_0008_..._0001_0000 (slot 0 in LSBs), busy low afterwards.
REQ-032 Saturation/sign: beats 0x7FFF_FFFF, 0x8000_0000, 0xFFFF_FF00, rest 0 -> slots 0x7FFF, 0x8000, 0xFFFF, 0x0000.
REQ-033 Backpressure gaps: in_valid toggled 1,0,1,0 over 20 cycles -> exactly 10 beats accepted, strobe one cycle after the 10th, no extra writes.
REQ-034 Abort: abort coincident with 10th beat -> no strobe, write_result_data keeps prior frame value, next start/frame completes normally.
REQ-035 Reset mid-frame: rst after 5 beats -> all outputs 0 next cycle, no strobe; in_valid without start -> in_ready stays 0, nothing stored.
REQ-036 Back-to-back frames: start asserted in IDLE directly after a strobe -> second frame collects and strobes its own data; start during COLLECT ignored (counter unaffected).
